// File: rtl/sar_result_fifo.sv
// sar_result_fifo: rebuilds 8-bit SAR codes MSB-first from the one-hot
// bit-enable bus. It aborts on an illegal enable sequence and queues finished
// codes in a first-word-fall-through FIFO with a valid/ready output.
module sar_result_fifo #(
  parameter int   DEPTH    = 4,
  parameter logic COMP_INV = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   VCOMP,
  input  logic [6:0]             OUTEN,
  input  logic                   SAR_RESET,
  output logic [7:0]             DOUT,
  output logic                   DVALID,
  input  logic                   DREADY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVERFLOW,
  output logic                   SEQERR
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRIAL = 2'd1;
  localparam logic [1:0] ST_LSB   = 2'd2;

  localparam logic [6:0]  OUTEN_MSB  = 7'b1000000;
  localparam logic [6:0]  OUTEN_NONE = 7'b0000000;
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

  // capture FSM
  logic [1:0]  state_r, state_nxt_s;
  logic [2:0]  k_r, k_nxt_s;
  logic [7:0]  shreg_r, shreg_nxt_s;
  logic        seqerr_r, seqerr_nxt_s;
  logic        comp_s;
  logic        push_s;
  logic [7:0]  push_word_s;

  // FIFO
  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [AW:0] level_r, level_nxt_s;
  logic [7:0]  dout_r, head_s;
  logic        dvalid_r, overflow_r;
  logic        full_s, pop_s, push_ok_s, drop_s, empty_nxt_s;

  assign comp_s   = VCOMP ^ COMP_INV;
  assign DOUT     = dout_r;
  assign DVALID   = dvalid_r;
  assign LEVEL    = level_r;
  assign OVERFLOW = overflow_r;
  assign SEQERR   = seqerr_r;

  // Next-state logic: shift the comparator bit in on each legal enable step,
  // flag and abort on any deviation (a stray MSB enable restarts at once).
  always_comb begin
    state_nxt_s  = state_r;
    k_nxt_s      = k_r;
    shreg_nxt_s  = shreg_r;
    seqerr_nxt_s = 1'b0;
    push_s       = 1'b0;
    push_word_s  = {shreg_r[6:0], comp_s};
    case (state_r)
      ST_IDLE: begin
        if (OUTEN == OUTEN_MSB) begin
          shreg_nxt_s = {7'd0, comp_s};
          k_nxt_s     = 3'd5;
          state_nxt_s = ST_TRIAL;
        end else begin
          shreg_nxt_s = 8'd0;
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TRIAL: begin
        if ((OUTEN == (7'd1 << k_r)) && !SAR_RESET) begin
          shreg_nxt_s = {shreg_r[6:0], comp_s};
          if (k_r == 3'd0) begin
            state_nxt_s = ST_LSB;
          end else begin
            k_nxt_s = k_r - 3'd1;
          end
        end else if (OUTEN == OUTEN_MSB) begin
          seqerr_nxt_s = 1'b1;
          shreg_nxt_s  = {7'd0, comp_s};
          k_nxt_s      = 3'd5;
          state_nxt_s  = ST_TRIAL;
        end else begin
          seqerr_nxt_s = 1'b1;
          shreg_nxt_s  = 8'd0;
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_LSB: begin
        if ((OUTEN == OUTEN_NONE) && !SAR_RESET) begin
          push_s      = 1'b1;
          shreg_nxt_s = 8'd0;
          state_nxt_s = ST_IDLE;
        end else if (OUTEN == OUTEN_MSB) begin
          seqerr_nxt_s = 1'b1;
          shreg_nxt_s  = {7'd0, comp_s};
          k_nxt_s      = 3'd5;
          state_nxt_s  = ST_TRIAL;
        end else begin
          seqerr_nxt_s = 1'b1;
          shreg_nxt_s  = 8'd0;
          state_nxt_s  = ST_IDLE;
        end
      end
      default: begin
        shreg_nxt_s = 8'd0;
        k_nxt_s     = 3'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Capture FSM registers and the registered sequence-error pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      k_r      <= 3'd0;
      shreg_r  <= 8'd0;
      seqerr_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      k_r      <= k_nxt_s;
      shreg_r  <= shreg_nxt_s;
      seqerr_r <= seqerr_nxt_s;
    end
  end

  // FIFO bookkeeping. The head is computed from the post-edge pointers so the
  // registered DOUT already shows a word written into an empty FIFO.
  always_comb begin
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s     = dvalid_r && DREADY;
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
    if (push_ok_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_s = push_word_s;
    end else begin
      head_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // FIFO storage; reset only blocks the write, stale contents are unreachable.
  always_ff @(posedge CLK) begin
    if (push_ok_s && !RESET) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_word_s;
    end
  end

  // Pointers and registered outputs; DOUT holds its last word when empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      level_r    <= {(AW+1){1'b0}};
      dout_r     <= 8'h00;
      dvalid_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      dvalid_r <= !empty_nxt_s;
      if (!empty_nxt_s) begin
        dout_r <= head_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sar_result_fifo.sv
// Bench for sar_result_fifo: directed SAR enable sequences, a history-based
// reference model compared every cycle, plus literal spot checks.
module tb_sar_result_fifo;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET, VCOMP, SAR_RESET, DREADY;
  logic [6:0] OUTEN;
  logic [7:0] DOUT, DOUT_I;
  logic       DVALID, DVALID_I, OVERFLOW, OVERFLOW_I, SEQERR, SEQERR_I;
  logic [2:0] LEVEL, LEVEL_I;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  sar_result_fifo #(.DEPTH(DEPTH), .COMP_INV(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .VCOMP(VCOMP), .OUTEN(OUTEN), .SAR_RESET(SAR_RESET),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW), .SEQERR(SEQERR));

  sar_result_fifo #(.DEPTH(DEPTH), .COMP_INV(1'b1)) dut_inv (
    .CLK(CLK), .RESET(RESET), .VCOMP(VCOMP), .OUTEN(OUTEN), .SAR_RESET(SAR_RESET),
    .DOUT(DOUT_I), .DVALID(DVALID_I), .DREADY(DREADY), .LEVEL(LEVEL_I),
    .OVERFLOW(OVERFLOW_I), .SEQERR(SEQERR_I));

  // free-running clock
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [6:0] h_outen [0:4095];
  logic       h_sr    [0:4095];
  logic       h_v     [0:4095];
  logic       h_rst   [0:4095];
  logic [7:0] q[$];
  logic [7:0] dout_m = 8'h00, dout_inv_m = 8'h00;
  logic       ovf_m = 1'b0, seqerr_m = 1'b0;

  // enable pattern of a conversion: MSB trial .. bit-1 trial, then all zero
  function automatic logic [6:0] exp_oe(input int pos);
    logic [6:0] msb;
    msb = 7'b1000000;
    if (pos < 7) return msb >> pos;
    else return 7'b0000000;
  endfunction

  function automatic bit pos_ok(input int c, input int pos);
    return (h_outen[c] == exp_oe(pos)) && ((pos == 0) || !h_sr[c]) && !h_rst[c];
  endfunction

  function automatic bit run_ok(input int start, input int len);
    for (int p = 0; p < len; p++)
      if (!pos_ok(start + p, p)) return 1'b0;
    return 1'b1;
  endfunction

  // at each edge: find the conversion in flight from input history, then update the queue
  always @(posedge CLK) begin : model
    int e, alen;
    bit done;
    logic [7:0] w;
    e = cyc_n;
    h_outen[e] = OUTEN; h_sr[e] = SAR_RESET; h_v[e] = VCOMP; h_rst[e] = RESET;
    if (RESET) begin
      q.delete();
      dout_m = 8'h00; dout_inv_m = 8'h00; ovf_m = 1'b0; seqerr_m = 1'b0;
    end else begin
      alen = 0;
      for (int j = 1; j <= 7; j++)
        if (j <= e && run_ok(e - j, j)) alen = j;
      done     = (alen == 7) && pos_ok(e, 7);
      seqerr_m = (alen > 0) && !pos_ok(e, alen);
      if (q.size() > 0 && DREADY) void'(q.pop_front());
      if (done) begin
        for (int p = 0; p < 8; p++) w[7-p] = h_v[e-7+p];
        if (q.size() < DEPTH) q.push_back(w);
        else ovf_m = 1'b1;
      end
      if (q.size() > 0) begin
        dout_m = q[0];
        dout_inv_m = ~q[0];
      end
    end
    cyc_n = cyc_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // compare both instances against the model on every falling edge
  always @(negedge CLK) begin
    if (cyc_n > 0) begin
      chk("dout",       DOUT,       dout_m);
      chk("dvalid",     DVALID,     q.size() > 0);
      chk("level",      LEVEL,      q.size());
      chk("overflow",   OVERFLOW,   ovf_m);
      chk("seqerr",     SEQERR,     seqerr_m);
      chk("inv_dout",   DOUT_I,     dout_inv_m);
      chk("inv_dvalid", DVALID_I,   q.size() > 0);
      chk("inv_level",  LEVEL_I,    q.size());
      chk("inv_ovf",    OVERFLOW_I, ovf_m);
      chk("inv_seqerr", SEQERR_I,   seqerr_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [6:0] oe, input logic sr, input logic v);
    OUTEN = oe; SAR_RESET = sr; VCOMP = v;
    @(posedge CLK); #1;
  endtask

  task automatic convert(input logic [7:0] w, input logic rdy_lsb);
    logic [6:0] msb;
    msb = 7'b1000000;
    for (int i = 0; i < 7; i++) cyc(msb >> i, 1'b0, w[7-i]);
    DREADY = rdy_lsb;
    cyc(7'b0000000, 1'b0, w[0]);
    DREADY = 1'b0;
  endtask

  task automatic drain_one(input logic [7:0] exp);
    chk("drain_dout", DOUT, exp);
    DREADY = 1'b1;
    cyc(7'b0000000, 1'b0, 1'b0);
    DREADY = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; OUTEN = 7'd0; SAR_RESET = 1'b0; VCOMP = 1'b0; DREADY = 1'b0;
    @(posedge CLK); #1;
    cyc(7'd0, 1'b0, 1'b0);
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_dvalid", DVALID, 1'b0);
    chk("rst_level", LEVEL, 3'd0);
    chk("rst_ovf", OVERFLOW, 1'b0);
    chk("rst_seqerr", SEQERR, 1'b0);
    RESET = 1'b0;

    // nominal conversion, 1,0,1,1,0,0,1,0 -> B2
    cyc(7'd0, 1'b1, 1'b0);
    convert(8'hB2, 1'b0);
    chk("nom_dout", DOUT, 8'hB2);
    chk("nom_dvalid", DVALID, 1'b1);
    chk("nom_level", LEVEL, 3'd1);
    drain_one(8'hB2);
    chk("nom_empty", DVALID, 1'b0);

    // back-pressure and overflow
    convert(8'h01, 1'b0); convert(8'h02, 1'b0);
    convert(8'h03, 1'b0); convert(8'h04, 1'b0);
    chk("bp_level4", LEVEL, 3'd4);
    chk("bp_no_ovf", OVERFLOW, 1'b0);
    convert(8'hFF, 1'b0);
    chk("bp_level_full", LEVEL, 3'd4);
    chk("bp_ovf", OVERFLOW, 1'b1);
    for (int i = 1; i <= 4; i++) drain_one(i[7:0]);
    chk("bp_empty", DVALID, 1'b0);
    chk("bp_ovf_sticky", OVERFLOW, 1'b1);

    // full FIFO with a pop on the LSB edge of 5A
    RESET = 1'b1; cyc(7'd0, 1'b0, 1'b0); RESET = 1'b0;
    convert(8'h11, 1'b0); convert(8'h22, 1'b0);
    convert(8'h33, 1'b0); convert(8'h44, 1'b0);
    convert(8'h5A, 1'b1);
    chk("fp_level", LEVEL, 3'd4);
    chk("fp_no_ovf", OVERFLOW, 1'b0);
    drain_one(8'h22); drain_one(8'h33); drain_one(8'h44); drain_one(8'h5A);
    chk("fp_empty", DVALID, 1'b0);

    // skipped bit -> sequence error, then a clean 80
    cyc(7'b1000000, 1'b0, 1'b1);
    cyc(7'b0100000, 1'b0, 1'b0);
    cyc(7'b0001000, 1'b0, 1'b0);
    chk("se_pulse", SEQERR, 1'b1);
    chk("se_level", LEVEL, 3'd0);
    cyc(7'd0, 1'b0, 1'b0);
    chk("se_pulse_end", SEQERR, 1'b0);
    convert(8'h80, 1'b0);
    chk("se_recover", DOUT, 8'h80);
    // a stray MSB enable aborts and restarts a conversion
    cyc(7'b1000000, 1'b0, 1'b1);
    cyc(7'b0100000, 1'b0, 1'b0);
    convert(8'hC3, 1'b0);
    chk("rs_level", LEVEL, 3'd2);
    drain_one(8'h80); drain_one(8'hC3);

    // SAR_RESET during trial k=2
    cyc(7'b1000000, 1'b0, 1'b1);
    cyc(7'b0100000, 1'b0, 1'b1);
    cyc(7'b0010000, 1'b0, 1'b1);
    cyc(7'b0001000, 1'b0, 1'b1);
    cyc(7'b0000100, 1'b1, 1'b1);
    chk("sr_pulse", SEQERR, 1'b1);
    chk("sr_level", LEVEL, 3'd0);
    cyc(7'd0, 1'b0, 1'b0);

    // RESET mid-conversion with a word queued
    convert(8'h77, 1'b0);
    chk("mr_level1", LEVEL, 3'd1);
    cyc(7'b1000000, 1'b0, 1'b1);
    cyc(7'b0100000, 1'b0, 1'b1);
    cyc(7'b0010000, 1'b0, 1'b1);
    RESET = 1'b1;
    cyc(7'b0001000, 1'b0, 1'b1);
    RESET = 1'b0;
    chk("mr_dout", DOUT, 8'h00);
    chk("mr_dvalid", DVALID, 1'b0);
    chk("mr_level", LEVEL, 3'd0);
    chk("mr_seqerr", SEQERR, 1'b0);
    cyc(7'b0000100, 1'b0, 1'b1);
    cyc(7'b0000010, 1'b0, 1'b1);
    cyc(7'b0000001, 1'b0, 1'b1);
    cyc(7'b0000000, 1'b0, 1'b1);
    chk("mr_no_push", LEVEL, 3'd0);

    // comparator polarity: VCOMP held low
    convert(8'h00, 1'b0);
    chk("pol_inv_dout", DOUT_I, 8'hFF);
    chk("pol_inv_dvalid", DVALID_I, 1'b1);
    chk("pol_dout", DOUT, 8'h00);
    chk("pol_level", LEVEL, 3'd1);

    cyc(7'd0, 1'b0, 1'b0);
    cyc(7'd0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
